// File: rtl/serial_pair_serializer.sv
// Serializes an (A, B) word pair MSB-first onto lock-stepped bit streams ai/bi, with frame strobes.
// Latency: first bit one cycle after accept; WIDTH bit cycles then GAP_CYCLES idle cycles.
// Backpressure: in_ready is high in IDLE, and on the last bit when GAP_CYCLES==0. Optional stall: SERIAL_STALL_EN.
module serial_pair_serializer #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
`ifdef SERIAL_STALL_EN
  input  logic             stall,
`endif
  output logic             ai,
  output logic             bi,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy,
  output logic [CNT_W-1:0] frames_sent
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_TOP  = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LOAD = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0]    cnt;
  logic [3:0]       gcnt;
  logic             hold;
  logic             load, adv, gap_load, gap_dec, frame_done;

`ifdef SERIAL_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next state, handshake and datapath controls
  always_comb begin
    state_d    = state;
    in_ready   = 1'b0;
    load       = 1'b0;
    adv        = 1'b0;
    gap_load   = 1'b0;
    gap_dec    = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!hold) begin
          adv = 1'b1;
          if (cnt == '0) begin
            frame_done = 1'b1;
            if (GAP_CYCLES > 0) begin
              gap_load = 1'b1;
              state_d  = GAP;
            end else begin
              // Zero-gap mode: the last bit cycle can take the next pair with no bubble
              in_ready = 1'b1;
              if (in_valid) load = 1'b1;
              else          state_d = IDLE;
            end
          end
        end
      end
      GAP: begin
        if (!hold) begin
          if (gcnt == '0) state_d = IDLE;
          else            gap_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift registers, bit counter, gap counter and frame counter
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh        <= '0;
      b_sh        <= '0;
      cnt         <= '0;
      gcnt        <= '0;
      frames_sent <= '0;
    end else begin
      if (load) begin
        a_sh <= a_word;
        b_sh <= b_word;
        cnt  <= CNT_TOP;
      end else if (adv) begin
        a_sh <= {a_sh[WIDTH-2:0], 1'b0};
        b_sh <= {b_sh[WIDTH-2:0], 1'b0};
        cnt  <= cnt - 1'b1;
      end
      if (gap_load)     gcnt <= GAP_LOAD;
      else if (gap_dec) gcnt <= gcnt - 1'b1;
      if (frame_done) frames_sent <= frames_sent + 1'b1;
    end
  end

  // Outputs decoded from registered state; a stall masks the strobes but holds ai/bi
  always_comb begin
    ai          = (state == SHIFT) & a_sh[WIDTH-1];
    bi          = (state == SHIFT) & b_sh[WIDTH-1];
    bit_valid   = (state == SHIFT) & ~hold;
    frame_start = bit_valid & (cnt == CNT_TOP);
    frame_last  = bit_valid & (cnt == '0);
    busy        = (state != IDLE);
  end

endmodule
